// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions, FSM states.
package alu_pkg;

    localparam logic [4:0] OP_PASSA = 5'd0;
    localparam logic [4:0] OP_PASSB = 5'd1;
    localparam logic [4:0] OP_NOTA  = 5'd2;
    localparam logic [4:0] OP_NOTB  = 5'd3;
    localparam logic [4:0] OP_ADD   = 5'd4;
    localparam logic [4:0] OP_ADC   = 5'd5;
    localparam logic [4:0] OP_SUB   = 5'd6;
    localparam logic [4:0] OP_AND   = 5'd7;
    localparam logic [4:0] OP_OR    = 5'd8;
    localparam logic [4:0] OP_XOR   = 5'd9;
    localparam logic [4:0] OP_NAND  = 5'd10;
    localparam logic [4:0] OP_LSL   = 5'd11;
    localparam logic [4:0] OP_LSR   = 5'd12;
    localparam logic [4:0] OP_ASR   = 5'd13;
    localparam logic [4:0] OP_CSL   = 5'd14;
    localparam logic [4:0] OP_CSR   = 5'd15;
    localparam logic [4:0] OP_MUL   = 5'd16;

    // Positions inside the {Z,C,N,O} flags register
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product accumulated per step.
module alu_mul_iter #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           srst,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product_next,
    output logic           last
);
    localparam int CNT_W = $clog2(W);

    logic [2*W-1:0]   mcand_reg;
    logic [2*W-1:0]   product_reg;
    logic [W-1:0]     mplier_reg;
    logic [CNT_W-1:0] count_reg;

    // The owner writes product_next when last is seen, so the final add is not lost
    assign product_next = product_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign last         = (count_reg == CNT_W'(W - 1));

    // Load operands, then per step: accumulate, shift multiplicand left, multiplier right
    always_ff @(posedge clk) begin
        if (srst) begin
            mcand_reg   <= '0;
            product_reg <= '0;
            mplier_reg  <= '0;
            count_reg   <= '0;
        end else if (load) begin
            mcand_reg   <= {{W{1'b0}}, a};
            product_reg <= '0;
            mplier_reg  <= b;
            count_reg   <= '0;
        end else if (step) begin
            product_reg <= product_next;
            mcand_reg   <= mcand_reg << 1;
            mplier_reg  <= mplier_reg >> 1;
            count_reg   <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU stage: single-cycle ops plus a 16-step multiply, registered result and flags.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [4:0]        FunSel,
    input  logic              WF,
    input  logic              Start,
    output logic [DATA_W-1:0] ALUOut,
    output logic [3:0]        FlagsOut,
    output logic              Busy,
    output logic              Done
);
    localparam int MSB = DATA_W - 1;

    state_t              state_reg;
    logic [DATA_W-1:0]   out_reg;
    logic [3:0]          flags_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                wf_reg;

    logic [DATA_W-1:0]   b_op;
    logic                c_in;
    logic [DATA_W:0]     sum_wide;
    logic                add_ovf;
    logic [DATA_W-1:0]   op_res;
    logic                op_valid;
    logic                c_new;
    logic                o_new;
    logic [3:0]          flags_single;
    logic [3:0]          flags_mul;

    logic                mul_load;
    logic                mul_step;
    logic [2*DATA_W-1:0] mul_prod;
    logic                mul_last;

    assign ALUOut   = out_reg;
    assign FlagsOut = flags_reg;
    assign Busy     = busy_reg;
    assign Done     = done_reg;

    assign mul_load = (state_reg == IDLE) && Start && (FunSel == OP_MUL);
    assign mul_step = (state_reg == MUL_RUN);

    alu_mul_iter #(.W(DATA_W)) u_mul (
        .clk          (Clock),
        .srst         (Reset),
        .load         (mul_load),
        .step         (mul_step),
        .a            (A),
        .b            (B),
        .product_next (mul_prod),
        .last         (mul_last)
    );

    // Single-cycle datapath; subtraction shares the adder as A + ~B + 1
    always_comb begin
        b_op     = (FunSel == OP_SUB) ? ~B : B;
        c_in     = (FunSel == OP_SUB) ? 1'b1 :
                   (FunSel == OP_ADC) ? flags_reg[FLAG_C] : 1'b0;
        sum_wide = {1'b0, A} + {1'b0, b_op} + {{DATA_W{1'b0}}, c_in};
        add_ovf  = (A[MSB] == b_op[MSB]) && (sum_wide[MSB] != A[MSB]);
        op_res   = '0;
        op_valid = 1'b1;
        c_new    = flags_reg[FLAG_C];
        o_new    = flags_reg[FLAG_O];
        case (FunSel)
            OP_PASSA: op_res = A;
            OP_PASSB: op_res = B;
            OP_NOTA:  op_res = ~A;
            OP_NOTB:  op_res = ~B;
            OP_ADD, OP_ADC, OP_SUB: begin
                op_res = sum_wide[MSB:0];
                c_new  = sum_wide[DATA_W];
                o_new  = add_ovf;
            end
            OP_AND:   op_res = A & B;
            OP_OR:    op_res = A | B;
            OP_XOR:   op_res = A ^ B;
            OP_NAND:  op_res = ~(A & B);
            OP_LSL: begin
                op_res = {A[MSB-1:0], 1'b0};
                c_new  = A[MSB];
            end
            OP_LSR: begin
                op_res = {1'b0, A[MSB:1]};
                c_new  = A[0];
            end
            OP_ASR: begin
                op_res = {A[MSB], A[MSB:1]};
                c_new  = A[0];
            end
            OP_CSL: begin
                op_res = {A[MSB-1:0], flags_reg[FLAG_C]};
                c_new  = A[MSB];
            end
            OP_CSR: begin
                op_res = {flags_reg[FLAG_C], A[MSB:1]};
                c_new  = A[0];
            end
            default:  op_valid = 1'b0;
        endcase
    end

    // Candidate flag words for the single-cycle path and for multiply completion
    always_comb begin
        flags_single         = flags_reg;
        flags_single[FLAG_Z] = (op_res == '0);
        flags_single[FLAG_C] = c_new;
        flags_single[FLAG_N] = op_res[MSB];
        flags_single[FLAG_O] = o_new;
        flags_mul            = flags_reg;
        flags_mul[FLAG_Z]    = (mul_prod[MSB:0] == '0);
        flags_mul[FLAG_C]    = |mul_prod[2*DATA_W-1:DATA_W];
        flags_mul[FLAG_N]    = mul_prod[MSB];
    end

    // Control FSM owning the result, flags, Busy and Done registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= IDLE;
            out_reg   <= '0;
            flags_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            wf_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        if (FunSel == OP_MUL) begin
                            state_reg <= MUL_RUN;
                            busy_reg  <= 1'b1;
                            wf_reg    <= WF;
                        end else begin
                            done_reg <= 1'b1;
                            if (op_valid) begin
                                out_reg <= op_res;
                                if (WF) begin
                                    flags_reg <= flags_single;
                                end
                            end
                        end
                    end
                end
                MUL_RUN: begin
                    if (mul_last) begin
                        out_reg   <= mul_prod[MSB:0];
                        if (wf_reg) begin
                            flags_reg <= flags_mul;
                        end
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed cases plus randomized traffic against a model.
module tb_alu_seq_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [4:0]  FunSel = '0;
    logic        WF = 1'b0;
    logic        Start = 1'b0;
    logic [15:0] ALUOut;
    logic [3:0]  FlagsOut;
    logic        Busy;
    logic        Done;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state
    logic [15:0] m_out   = '0;
    logic [3:0]  m_flags = '0;
    logic        m_busy  = 1'b0;
    logic        m_done  = 1'b0;
    int          m_left  = 0;
    logic [31:0] m_prod  = '0;
    logic        m_wf    = 1'b0;

    alu_seq_unit #(.DATA_W(16)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .A        (A),
        .B        (B),
        .FunSel   (FunSel),
        .WF       (WF),
        .Start    (Start),
        .ALUOut   (ALUOut),
        .FlagsOut (FlagsOut),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Arithmetic reference for one single-cycle op, using integer math
    function automatic void model_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                     input logic cin, output logic [15:0] r, output bit valid,
                                     output bit c_set, output logic c, output bit o_set, output logic o);
        int ua, ub, sa, sb, s, ss;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        s = 0; ss = 0;
        r = '0; valid = 1'b1; c_set = 1'b0; c = 1'b0; o_set = 1'b0; o = 1'b0;
        case (op)
            5'd0:  r = a;
            5'd1:  r = b;
            5'd2:  r = ~a;
            5'd3:  r = ~b;
            5'd4, 5'd5: begin
                s  = ua + ub + ((op == 5'd5) ? int'(cin) : 0);
                ss = sa + sb + ((op == 5'd5) ? int'(cin) : 0);
                r = s[15:0]; c_set = 1'b1; c = (s > 65535);
                o_set = 1'b1; o = (ss > 32767) || (ss < -32768);
            end
            5'd6: begin
                s = ua - ub; ss = sa - sb;
                r = s[15:0]; c_set = 1'b1; c = (ua >= ub);
                o_set = 1'b1; o = (ss > 32767) || (ss < -32768);
            end
            5'd7:  r = a & b;
            5'd8:  r = a | b;
            5'd9:  r = a ^ b;
            5'd10: r = ~(a & b);
            5'd11: begin r = a << 1; c_set = 1'b1; c = a[15]; end
            5'd12: begin r = a >> 1; c_set = 1'b1; c = a[0]; end
            5'd13: begin s = sa >>> 1; r = s[15:0]; c_set = 1'b1; c = a[0]; end
            5'd14: begin r = {a[14:0], cin}; c_set = 1'b1; c = a[15]; end
            5'd15: begin r = {cin, a[15:1]}; c_set = 1'b1; c = a[0]; end
            default: valid = 1'b0;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs currently driven
    task automatic model_update();
        logic [15:0] r;
        bit valid, c_set, o_set;
        logic c, o;
        if (Reset) begin
            m_out = '0; m_flags = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_out = m_prod[15:0];
                    if (m_wf) begin
                        m_flags[3] = (m_prod[15:0] == 16'h0);
                        m_flags[2] = (m_prod[31:16] != 16'h0);
                        m_flags[1] = m_prod[15];
                    end
                end
            end else if (Start) begin
                if (FunSel == 5'd16) begin
                    m_left = 16; m_busy = 1'b1; m_wf = WF;
                    m_prod = 32'(A) * 32'(B);
                end else begin
                    m_done = 1'b1;
                    model_op(FunSel, A, B, m_flags[2], r, valid, c_set, c, o_set, o);
                    if (valid) begin
                        m_out = r;
                        if (WF) begin
                            m_flags[3] = (r == 16'h0);
                            m_flags[1] = r[15];
                            if (c_set) m_flags[2] = c;
                            if (o_set) m_flags[0] = o;
                        end
                    end
                end
            end
        end
    endtask

    // Drive one cycle, step the model at the edge, compare at the falling edge
    task automatic cycle(input bit rst, input bit st, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] fs, input bit wf);
        Reset = rst; Start = st; A = a; B = b; FunSel = fs; WF = wf;
        @(posedge Clock);
        model_update();
        @(negedge Clock);
        check("aluout", {16'h0, ALUOut}, {16'h0, m_out});
        check("flags", {28'h0, FlagsOut}, {28'h0, m_flags});
        check("busy", {31'h0, Busy}, {31'h0, m_busy});
        check("done", {31'h0, Done}, {31'h0, m_done});
    endtask

    function automatic logic [15:0] pick_operand();
        logic [15:0] v;
        case ($urandom_range(0, 7))
            0: v = 16'h0000;
            1: v = 16'h7FFF;
            2: v = 16'h8000;
            3: v = 16'hFFFF;
            4: v = 16'h0001;
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        int busy_cnt;
        int done_at;
        int done_cnt;

        cycle(1, 0, 16'h0, 16'h0, 5'd0, 0);
        cycle(1, 1, 16'hFFFF, 16'hFFFF, 5'd4, 1);
        check("reset_out", {16'h0, ALUOut}, 32'h0);
        check("reset_flags", {28'h0, FlagsOut}, 32'h0);

        cycle(0, 1, 16'h7FFF, 16'h0001, 5'd4, 1);
        $display("txn ADD 7fff+0001 -> %h flags %b done %b", ALUOut, FlagsOut, Done);
        check("add_out", {16'h0, ALUOut}, 32'h8000);
        check("add_flags", {28'h0, FlagsOut}, 32'b0011);
        check("add_done", {31'h0, Done}, 32'h1);
        cycle(0, 0, 16'h0, 16'h0, 5'd0, 0);
        check("add_done_clr", {31'h0, Done}, 32'h0);

        cycle(0, 1, 16'h0005, 16'h0005, 5'd6, 1);
        $display("txn SUB 0005-0005 -> %h flags %b", ALUOut, FlagsOut);
        check("sub_out", {16'h0, ALUOut}, 32'h0000);
        check("sub_flags", {28'h0, FlagsOut}, 32'b1100);
        cycle(0, 1, 16'h0003, 16'h0001, 5'd6, 0);
        $display("txn SUB 0003-0001 nowf -> %h flags %b", ALUOut, FlagsOut);
        check("sub_nowf_out", {16'h0, ALUOut}, 32'h0002);
        check("sub_nowf_flags", {28'h0, FlagsOut}, 32'b1100);

        cycle(0, 1, 16'h8001, 16'h0, 5'd14, 1);
        $display("txn CSL 8001 c=1 -> %h flags %b", ALUOut, FlagsOut);
        check("csl_out", {16'h0, ALUOut}, 32'h0003);
        check("csl_flags", {28'h0, FlagsOut}, 32'b0100);
        cycle(0, 1, 16'h0003, 16'h0, 5'd15, 1);
        $display("txn CSR 0003 c=1 -> %h flags %b", ALUOut, FlagsOut);
        check("csr_out", {16'h0, ALUOut}, 32'h8001);
        check("csr_flags", {28'h0, FlagsOut}, 32'b0110);

        cycle(0, 1, 16'h0100, 16'h0300, 5'd16, 1);
        busy_cnt = Busy ? 1 : 0;
        done_at = -1;
        for (int i = 1; i <= 16; i++) begin
            if (i == 3) cycle(0, 1, 16'hFFFF, 16'hFFFF, 5'd4, 1);
            else        cycle(0, 0, 16'h0, 16'h0, 5'd0, 0);
            if (Busy) busy_cnt++;
            if (Done && done_at < 0) done_at = i;
        end
        $display("txn MUL 0100*0300 -> %h flags %b busy_cycles %0d done_at %0d", ALUOut, FlagsOut, busy_cnt, done_at);
        check("mul_busy_cycles", 32'(busy_cnt), 32'd16);
        check("mul_done_at", 32'(done_at), 32'd16);
        check("mul_out", {16'h0, ALUOut}, 32'h0000);
        check("mul_flags", {28'h0, FlagsOut}, 32'b1100);

        cycle(0, 1, 16'h1234, 16'h0, 5'd0, 0);
        cycle(0, 1, 16'hFFFF, 16'h0001, 5'd20, 1);
        $display("txn RSV 20 -> %h flags %b done %b", ALUOut, FlagsOut, Done);
        check("rsv_out", {16'h0, ALUOut}, 32'h1234);
        check("rsv_flags", {28'h0, FlagsOut}, 32'b1100);
        check("rsv_done", {31'h0, Done}, 32'h1);

        cycle(0, 1, 16'h1234, 16'h5678, 5'd16, 1);
        for (int i = 1; i <= 4; i++) cycle(0, 0, 16'h0, 16'h0, 5'd0, 0);
        cycle(1, 0, 16'h0, 16'h0, 5'd0, 0);
        $display("txn RESET mid-MUL -> %h flags %b busy %b done %b", ALUOut, FlagsOut, Busy, Done);
        check("abort_out", {16'h0, ALUOut}, 32'h0);
        check("abort_flags", {28'h0, FlagsOut}, 32'h0);
        check("abort_busy", {31'h0, Busy}, 32'h0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 16'h0, 16'h0, 5'd0, 0);
            if (Done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            bit rst, st, wf;
            logic [4:0] fs;
            int sel;
            rst = ($urandom_range(0, 299) == 0);
            st  = ($urandom_range(0, 3) != 0);
            wf  = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 19);
            fs  = (sel < 17) ? 5'(sel) : 5'($urandom_range(17, 31));
            cycle(rst, st, pick_operand(), pick_operand(), fs, wf);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Sequential ALU stage directly downstream of the register file.
- Consumes the register file's OutA/OutB as operands A/B and produces a registered result plus a 4-bit flags register (Z,C,N,O).
- The result feeds the register file's I input and the memory/address path.
- Single-cycle ops complete one edge after Start; MUL is a 16-iteration shift-add operation with Busy/Done handshake.

Parameters:
- DATA_W, 16, operand/result width; all rules below assume 16.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- A  input  16  operand A (register file OutA).
- B  input  16  operand B (register file OutB).
- FunSel  input  5  operation select, sampled with Start.
- WF  input  1  write-flags enable, sampled with Start.
- Start  input  1  begin operation; ignored while Busy=1.
- ALUOut  output  16  registered result.
- FlagsOut  output  4  {Z,C,N,O}, Z = bit 3.
- Busy  output  1  high during MUL iterations.
- Done  output  1  one-cycle pulse when result/flags are updated.

Behaviour:
- Clock and reset: one clock, Clock. Reset is synchronous and active-high.
- Reset values: ALUOut=0, FlagsOut=0, Busy=0, Done=0, FSM=IDLE, multiplier state cleared. Reset has priority over Start. Reset during MUL aborts the operation with no Done.
- FSM states:
  - IDLE: Start=1 latches A, B, FunSel, WF.
    - Single-cycle op: result and flags are written at that same edge; Done=1 for the next cycle; state stays IDLE.
    - FunSel=16 (MUL): go to MUL_RUN, Busy=1, iteration counter=0.
  - MUL_RUN: one iteration per edge. When the counter reaches 15, the product low 16 bits are written to ALUOut at that edge, flags are written if WF, Done=1, Busy=0, state goes to IDLE.
  - Timing: Start at edge k gives Done visible after edge k+16. Start while Busy is ignored, and latched operands are unaffected.
- Operations (FunSel):
  - 0 A; 1 B; 2 ~A; 3 ~B
  - 4 A+B; 5 A+B+C; 6 A-B
  - 7 AND; 8 OR; 9 XOR; 10 NAND
  - 11 LSL A; 12 LSR A; 13 ASR A
  - 14 CSL A (rotate left through C); 15 CSR A (rotate right through C)
  - 16 MUL, unsigned A*B, low 16 bits
  - 17-31 reserved: Done pulses, ALUOut and flags unchanged.
- Flag rules (applied only when latched WF=1; otherwise FlagsOut holds):
  - Z = (result==0) and N = result[15], for all ops.
  - ADD/ADC: C = carry out of bit 15. O = signed overflow (operand signs equal, result sign differs).
  - SUB: computed as A+~B+1. C = carry out (1 = no borrow). O = signed overflow.
  - Shifts/rotates: C = bit shifted out. O unchanged.
  - Logic/pass ops: C and O unchanged.
  - MUL: C = 1 if upper 16 product bits are nonzero. O unchanged.
- ADC uses the C value in FlagsOut at the Start edge.
- Back-to-back Start on consecutive cycles is legal for single-cycle ops, one result per cycle.

Decomposition:
- Shared package alu_pkg holds:
  - FunSel opcode constants (OP_PASSA..OP_MUL);
  - flag bit indices FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_O=0;
  - FSM state encoding IDLE/MUL_RUN.
- One sub-module, alu_mul_iter: 16-step shift-add multiplier with load/step inputs, a 32-bit product register, and a last flag. The top level holds the FSM, the single-cycle datapath and the flags register.

Test Plan:
- Reset asserted mid-MUL (cycle 5 of 16) -> next cycle ALUOut=0, FlagsOut=0, Busy=0, no Done pulse.
- A=0x7FFF, B=0x0001, FunSel=4, WF=1, Start -> next cycle ALUOut=0x8000, flags Z0 C0 N1 O1, Done=1 for exactly one cycle.
- A=0x0005, B=0x0005, FunSel=6, WF=1 -> ALUOut=0x0000, Z1 C1 N0 O0. Repeat with WF=0 -> flags unchanged.
- C=1 preset, A=0x8001, FunSel=14 -> ALUOut=0x0003, C=1. Then FunSel=15 on 0x0003 with C=1 -> 0x8001, C=1.
- A=0x0100, B=0x0300, FunSel=16, WF=1 -> Busy=1 for 16 cycles, Done after edge k+16, ALUOut=0x0000, Z1 C1 N0. A second Start during Busy is ignored.
- FunSel=20 reserved, with ALUOut=0x1234 beforehand -> Done pulses, ALUOut stays 0x1234, flags unchanged.
